// File: rtl/spi_mem_host_ctrl_pkg.sv
// Shared types and constants for the SPI memory host (states, frame geometry, frame builder).
// SPI_HOST_VERIFY_EN adds the VREAD_SETUP state used by the write read-back check.
package spi_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
`ifdef SPI_HOST_VERIFY_EN
    ,
    VREAD_SETUP
`endif
  } state_t;

  localparam int   FRAME_BITS = 16;
  localparam int   ADDR_BITS  = 7;
  localparam int   DATA_BITS  = 8;
  localparam logic RW_READ    = 1'b1;

  // Reads always carry a zero data byte so the memory sees a clean dummy field.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [ADDR_BITS-1:0] addr,
    input logic                 rw,
    input logic [DATA_BITS-1:0] wdata
  );
    return {addr, rw, (rw == RW_READ) ? {DATA_BITS{1'b0}} : wdata};
  endfunction

endpackage

// File: rtl/spi_mem_host_ctrl_if.sv
// Request/response bundle between system logic (master) and the SPI memory host (slave).
interface spi_mem_host_ctrl_if;
  import spi_host_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_rw;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_wdata;
  logic                 rsp_valid;
  logic [DATA_BITS-1:0] rsp_rdata;
  logic                 busy;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/spi_mem_host_ctrl_tick.sv
// Half-period divider: tick on count CLKDIV-1, held cleared while en is low.
module sclk_tick_gen #(
  parameter int CLKDIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(CLKDIV);
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_mem_host_ctrl.sv
// SPI mode-0 host: one 16-bit {addr,rw,data} frame per accepted request, rsp pulse 34*CLKDIV+1 cycles later.
// SPI_HOST_VERIFY_EN: each write is followed by a read-back of the same address before responding.
module spi_mem_host_ctrl
  import spi_host_pkg::*;
#(
  parameter int CLKDIV = 50,
  parameter int CS_GAP = 2
) (
  input  logic clk,
  input  logic reset,
  spi_mem_host_ctrl_if.slave bus,
  output logic cs,
  output logic sclk,
  output logic mosi,
  input  logic miso
`ifdef SPI_HOST_VERIFY_EN
  ,
  output logic verify_err
`endif
);

  localparam int GAP_CYC = CS_GAP * CLKDIV;
  localparam int GW      = $clog2(GAP_CYC);
  localparam int BW      = $clog2(FRAME_BITS + 1);

  state_t                  state;
  logic [FRAME_BITS-1:0]   frame;
  logic [DATA_BITS-1:0]    rdata_sr;
  logic [BW-1:0]           bit_cnt;
  logic                    rw;
  logic [GW-1:0]           gap_cyc;
  logic                    div_en;
  logic                    tick;
`ifdef SPI_HOST_VERIFY_EN
  logic                    verify_pend;
  logic                    verify_rd;
  logic [ADDR_BITS-1:0]    v_addr;
  logic [DATA_BITS-1:0]    v_wdata;
`endif

  assign div_en        = (state != IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.req_ready = (state == IDLE) && !reset;

  sclk_tick_gen #(.CLKDIV(CLKDIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (div_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cs            <= 1'b1;
      sclk          <= 1'b0;
      mosi          <= 1'b0;
      frame         <= '0;
      rdata_sr      <= '0;
      bit_cnt       <= '0;
      rw            <= 1'b0;
      gap_cyc       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
`ifdef SPI_HOST_VERIFY_EN
      verify_pend   <= 1'b0;
      verify_rd     <= 1'b0;
      v_addr        <= '0;
      v_wdata       <= '0;
      verify_err    <= 1'b0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cs   <= 1'b1;
          sclk <= 1'b0;
          if (bus.req_valid) begin
            frame <= build_frame(bus.req_addr, bus.req_rw, bus.req_wdata);
            rw    <= bus.req_rw;
            cs    <= 1'b0;
            mosi  <= bus.req_addr[ADDR_BITS-1];
            state <= SETUP;
`ifdef SPI_HOST_VERIFY_EN
            v_addr    <= bus.req_addr;
            v_wdata   <= bus.req_wdata;
            verify_rd <= 1'b0;
`endif
          end
        end

        SETUP: begin
          if (tick) begin
            sclk    <= 1'b1;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end

`ifdef SPI_HOST_VERIFY_EN
        VREAD_SETUP: begin
          if (tick) begin
            sclk    <= 1'b1;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
`endif

        SHIFT: begin
          if (tick) begin
            if (sclk) begin
              // miso is sampled as late as possible in the high half, just before sclk falls
              if (rw == RW_READ && bit_cnt >= BW'(DATA_BITS)) begin
                rdata_sr <= {rdata_sr[DATA_BITS-2:0], miso};
              end
              frame   <= frame << 1;
              mosi    <= frame[FRAME_BITS-2];
              bit_cnt <= bit_cnt + 1'b1;
              sclk    <= 1'b0;
            end else if (bit_cnt == BW'(FRAME_BITS)) begin
              state <= HOLD;
            end else begin
              sclk <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (tick) begin
            cs      <= 1'b1;
            gap_cyc <= '0;
            state   <= GAP;
`ifdef SPI_HOST_VERIFY_EN
            if (rw != RW_READ) begin
              verify_pend <= 1'b1;
            end else begin
              bus.rsp_valid <= 1'b1;
              if (verify_rd) begin
                verify_err <= (rdata_sr != v_wdata);
              end else begin
                bus.rsp_rdata <= rdata_sr;
                verify_err    <= 1'b0;
              end
            end
`else
            bus.rsp_valid <= 1'b1;
            if (rw == RW_READ) begin
              bus.rsp_rdata <= rdata_sr;
            end
`endif
          end
        end

        GAP: begin
          gap_cyc <= gap_cyc + 1'b1;
          // Leaving one cycle early lets the IDLE acceptance cycle complete the cs-high gap.
`ifdef SPI_HOST_VERIFY_EN
          if (verify_pend) begin
            if (gap_cyc == GW'(GAP_CYC - 1)) begin
              frame       <= build_frame(v_addr, RW_READ, '0);
              rw          <= RW_READ;
              verify_pend <= 1'b0;
              verify_rd   <= 1'b1;
              cs          <= 1'b0;
              mosi        <= v_addr[ADDR_BITS-1];
              state       <= VREAD_SETUP;
            end
          end else if (gap_cyc == GW'(GAP_CYC - 2)) begin
            state <= IDLE;
          end
`else
          if (gap_cyc == GW'(GAP_CYC - 2)) begin
            state <= IDLE;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_host_ctrl.sv
// Scoreboard bench for spi_mem_host_ctrl with a behavioural mode-0 SPI byte memory.
module tb_spi_mem_host_ctrl;
  import spi_host_pkg::*;

  localparam int CLKDIV    = 50;
  localparam int CS_GAP    = 2;
  localparam int FRAME_LAT = 34 * CLKDIV + 1;
  localparam int B2B       = (34 + CS_GAP) * CLKDIV;
  localparam int BUDGET    = 8000;
`ifdef SPI_HOST_VERIFY_EN
  localparam int WR_LAT    = (68 + CS_GAP) * CLKDIV + 1;
  localparam bit VERIFY    = 1'b1;
`else
  localparam int WR_LAT    = FRAME_LAT;
  localparam bit VERIFY    = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic cs, sclk, mosi;
  logic miso  = 1'b0;
`ifdef SPI_HOST_VERIFY_EN
  logic verify_err;
`endif

  spi_mem_host_ctrl_if bus ();

  spi_mem_host_ctrl #(.CLKDIV(CLKDIV), .CS_GAP(CS_GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .cs    (cs),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso)
`ifdef SPI_HOST_VERIFY_EN
    ,
    .verify_err (verify_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- SPI memory model ----------------
  logic [7:0]  mem [128];
  logic [15:0] msr        = '0;
  logic [15:0] last_frame = '0;
  int          mcnt       = 0;
  logic        rd_is      = 1'b0;
  logic [7:0]  rd_byte    = '0;
  logic        force_aa   = 1'b0;

  initial for (int i = 0; i < 128; i++) mem[i] = 8'(i * 3 + 7);

  always @(negedge cs) begin
    mcnt = 0;
    msr  = '0;
  end

  always @(posedge sclk) if (!cs) begin
    msr = {msr[14:0], mosi};
    mcnt++;
  end

  always @(negedge sclk) if (!cs) begin
    if (mcnt == 8) begin
      rd_is   = msr[0];
      rd_byte = force_aa ? 8'hAA : mem[msr[7:1]];
    end
    miso = (rd_is && mcnt >= 8 && mcnt < 16) ? rd_byte[3'(15 - mcnt)] : 1'b0;
  end

  always @(posedge cs) if (mcnt == 16) begin
    last_frame = msr;
    if (!msr[8]) mem[msr[15:9]] = msr[7:0];
    rd_is = 1'b0;
  end

  // ---------------- scoreboard and pin monitors ----------------
  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
    logic        verr;
    int          lat;
  } exp_t;

  exp_t       exp_q[$];
  int         acc_q[$];
  int         cyc      = 0;
  int         rsp_cnt  = 0;
  logic [7:0] hold_rd  = 8'h00;
  logic       prev_rsp = 1'b0, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs = 1'b1;
  int         low_cnt  = 0;
  int         high_cnt = CS_GAP * CLKDIV;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (reset) begin
      acc_q.delete();
      prev_rsp = 1'b0;
      high_cnt = CS_GAP * CLKDIV;
    end else begin
      if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
      if (bus.rsp_valid) begin
        rsp_cnt++;
        if (prev_rsp) chk("rsp_pulse_width", 32'(bus.rsp_valid), 32'd0);
        else if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -1;
          chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
          chk("rsp_latency", 32'(cyc - a), 32'(e.lat));
          chk("mosi_frame", 32'(last_frame), 32'(e.frame));
`ifdef SPI_HOST_VERIFY_EN
          chk("verify_err", 32'(verify_err), 32'(e.verr));
`endif
        end
      end
      if (prev_sclk && sclk && mosi !== prev_mosi) chk("mosi_change_sclk_high", 32'(mosi), 32'(prev_mosi));
      if (prev_sclk && cs !== prev_cs) chk("cs_change_sclk_high", 32'(cs), 32'(prev_cs));
      if (!prev_cs && cs) begin
        chk("cs_low_len", 32'(low_cnt), 32'(34 * CLKDIV));
        high_cnt = 0;
      end
      if (prev_cs && !cs) begin
        chk("cs_gap_min", 32'(high_cnt >= CS_GAP * CLKDIV), 32'd1);
        low_cnt = 0;
      end
      if (cs) high_cnt++;
      else low_cnt++;
      prev_rsp = bus.rsp_valid;
    end
    prev_cs   = cs;
    prev_sclk = sclk;
    prev_mosi = mosi;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input logic exp_verr, input bit push);
    exp_t e;
    int   n;
    e.frame = (rw || VERIFY) ? {a, 1'b1, 8'h00} : {a, 1'b0, wd};
    e.rdata = rw ? exp_rd : hold_rd;
    e.verr  = exp_verr;
    e.lat   = rw ? FRAME_LAT : WR_LAT;
    if (rw) hold_rd = exp_rd;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) chk("accept_timeout", 32'(n), 32'(BUDGET - 1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int n0, input int want);
    int n;
    n = 0;
    while (rsp_cnt < n0 + want && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("rsp_count", 32'(rsp_cnt - n0), 32'(want));
  endtask

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input logic exp_verr);
    int n0;
    n0 = rsp_cnt;
    issue(rw, a, wd, exp_rd, exp_verr, 1'b1);
    bus.req_valid = 1'b0;
    wait_rsp(n0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t1, t2, n0, n;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    send(1'b0, 7'h01, 8'h55, 8'h00, 1'b0);
    send(1'b1, 7'h01, 8'h00, 8'h55, 1'b0);
    send(1'b0, 7'h01, 8'h00, 8'h00, 1'b0);
    send(1'b1, 7'h01, 8'h00, 8'h00, 1'b0);

    // two queued reads with req_valid held high
    n0 = rsp_cnt;
    issue(1'b1, 7'h02, 8'h00, 8'h0D, 1'b0, 1'b1);
    t1 = cyc;
    issue(1'b1, 7'h03, 8'h00, 8'h10, 1'b0, 1'b1);
    t2 = cyc;
    bus.req_valid = 1'b0;
    chk("b2b_spacing", 32'(t2 - t1), 32'(B2B));
    wait_rsp(n0, 2);

    // abort a write at bit 5 with reset
    n0 = rsp_cnt;
    issue(1'b0, 7'h7F, 8'h77, 8'h00, 1'b0, 1'b0);
    bus.req_valid = 1'b0;
    n = 0;
    while (mcnt < 5 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_bit5", 32'(mcnt), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("abort_cs", 32'(cs), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_mosi", 32'(mosi), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    hold_rd = 8'h00;
    repeat (CLKDIV * 40) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_cnt - n0), 32'd0);
    send(1'b1, 7'h01, 8'h00, 8'h00, 1'b0);
    send(1'b1, 7'h7F, 8'h00, 8'h84, 1'b0);

`ifdef SPI_HOST_VERIFY_EN
    force_aa = 1'b1;
    send(1'b0, 7'h04, 8'h55, 8'h00, 1'b1);
    force_aa = 1'b0;
    send(1'b0, 7'h04, 8'h33, 8'h00, 1'b0);
    send(1'b1, 7'h04, 8'h00, 8'h33, 1'b0);
`endif

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
